// File: rtl/reg_scoreboard.sv
// GPR pending-write scoreboard for a decode stage.
// Tracks, per register 1..31, whether a write is in flight (pending bit) and
// how many cycles remain until its result reaches the forward path (countdown).
// Produces a combinational decode stall plus per-operand forward selects.
// Optional feature macro: SB_FORWARD_EN. When defined, operands whose producer
// result is forwardable in time are forwarded instead of stalling.
// Without it, any pending source stalls until its writeback edge.
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [2:0]  issue_tnew,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        rs_used,
    input  logic        rt_used,
    input  logic [2:0]  rs_tuse,
    input  logic [2:0]  rt_tuse,
    output logic        stall,
    output logic        fwd_rs,
    output logic        fwd_rt,
    output logic [31:0] pending,
    output logic        wb_err
);

    // Entry 0 exists only to keep indexing uniform; it is forced to zero.
    logic [31:0] pend_q, pend_d;
    logic [2:0]  cnt_q [32];
    logic [2:0]  cnt_d [32];
    logic        wb_err_q, wb_err_d;

    logic        src_rs_pend, src_rt_pend;
    logic        haz_rs, haz_rt;

    // Source lookup: only current state and decode operands, never issue_*.
    always_comb begin
        src_rs_pend = rs_used && (rs != 5'd0) && pend_q[rs];
        src_rt_pend = rt_used && (rt != 5'd0) && pend_q[rt];
`ifdef SB_FORWARD_EN
        haz_rs = src_rs_pend && (cnt_q[rs] > rs_tuse);
        haz_rt = src_rt_pend && (cnt_q[rt] > rt_tuse);
        fwd_rs = src_rs_pend && (cnt_q[rs] <= rs_tuse);
        fwd_rt = src_rt_pend && (cnt_q[rt] <= rt_tuse);
`else
        haz_rs = src_rs_pend;
        haz_rt = src_rt_pend;
        fwd_rs = 1'b0;
        fwd_rt = 1'b0;
`endif
        stall = haz_rs || haz_rt;
    end

`ifndef SB_FORWARD_EN
    // Operand timing is irrelevant when every pending source stalls.
    logic unused_tuse;
    assign unused_tuse = ^{rs_tuse, rt_tuse};
`endif

    // Next state: countdown, then writeback clear, then issue (issue wins).
    always_comb begin
        pend_d   = pend_q;
        wb_err_d = 1'b0;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (pend_q[r] && (cnt_q[r] != 3'd0)) ? cnt_q[r] - 3'd1 : cnt_q[r];
        end
        if (wb_valid && (wb_rd != 5'd0)) begin
            wb_err_d      = ~pend_q[wb_rd];
            pend_d[wb_rd] = 1'b0;
        end
        if (issue_valid && !stall && (issue_rd != 5'd0)) begin
            pend_d[issue_rd] = 1'b1;
            cnt_d[issue_rd]  = issue_tnew;
        end
        pend_d[0] = 1'b0;
        cnt_d[0]  = 3'd0;
    end

    // State registers; synchronous reset discards any concurrent issue/writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            wb_err_q <= 1'b0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            pend_q   <= pend_d;
            wb_err_q <= wb_err_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign pending = pend_q;
    assign wb_err  = wb_err_q;

endmodule
